// File: rtl/uart_data_fifo_pkg.sv
// Shared UART FIFO types and sizing constants.
// Used by the register block and the TX/RX data FIFOs.
package uart_data_fifo_pkg;

  localparam int unsigned TX_FIFO_SIZE = 8;
  localparam int unsigned RX_FIFO_SIZE = 8;

  localparam int unsigned FIFO_CNT_W =
    $clog2(((TX_FIFO_SIZE > RX_FIFO_SIZE) ?
            TX_FIFO_SIZE : RX_FIFO_SIZE) + 1);

  localparam logic [FIFO_CNT_W-1:0] TX_THRESH_DEF =
    FIFO_CNT_W'(2);
  localparam logic [FIFO_CNT_W-1:0] RX_THRESH_DEF =
    FIFO_CNT_W'(1);

  typedef struct packed {
    logic [FIFO_CNT_W-1:0] count;
    logic                  full;
    logic                  empty;
    logic                  thresh;
    logic                  overflow;
    logic                  underflow;
  } fifo_status_t;

endpackage

// File: rtl/uart_fifo_ptr.sv
// Wrap-around pointer: counts 0..MAX, wraps by explicit compare.
// Synchronous clear has priority over enable.
module uart_fifo_ptr #(
  parameter int unsigned MAX = 7,
  parameter int unsigned W   = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
  input  logic         clk_i,
  input  logic         arst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] ptr_o
);

  localparam logic [W-1:0] MAX_P = W'(MAX);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ptr_o <= '0;
    end else if (clr_i) begin
      ptr_o <= '0;
    end else if (en_i) begin
      ptr_o <= (ptr_o == MAX_P) ? '0 : ptr_o + 1'b1;
    end
  end

endmodule

// File: rtl/uart_data_fifo.sv
// UART TX/RX data FIFO: FWFT peek, flush, fill threshold,
// sticky overflow/underflow flags.
module uart_data_fifo
  import uart_data_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = TX_FIFO_SIZE,
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  input  logic [CNT_WIDTH-1:0]  thresh_i,
  output logic                  thresh_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  clr_err_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  ovf_set;
  logic                  unf_set;

  assign full_o  = (count == DEPTH_C);
  assign empty_o = (count == '0);
  assign count_o = count;

  // A pop frees the slot, so a full FIFO can take push+pop together.
  assign pop_acc  = pop_i & ~empty_o & ~flush_i;
  assign push_acc = push_i & (~full_o | pop_acc) & ~flush_i;
  assign ovf_set  = push_i & full_o & ~pop_acc & ~flush_i;
  assign unf_set  = pop_i & empty_o & ~flush_i;

  assign data_o   = empty_o ? '0 : mem[rd_ptr];
  assign thresh_o = (thresh_i != '0) && (count >= thresh_i);

  uart_fifo_ptr #(
    .MAX (DEPTH - 1),
    .W   (PTR_W)
  ) u_wr_ptr (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .clr_i   (flush_i),
    .en_i    (push_acc),
    .ptr_o   (wr_ptr)
  );

  uart_fifo_ptr #(
    .MAX (DEPTH - 1),
    .W   (PTR_W)
  ) u_rd_ptr (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .clr_i   (flush_i),
    .en_i    (pop_acc),
    .ptr_o   (rd_ptr)
  );

  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      count <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else if (push_acc & ~pop_acc) begin
      count <= count + 1'b1;
    end else if (pop_acc & ~push_acc) begin
      count <= count - 1'b1;
    end
  end

  // Set wins over clear in the same cycle.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= ovf_set | (overflow_o & ~clr_err_i);
      underflow_o <= unf_set | (underflow_o & ~clr_err_i);
    end
  end

endmodule

// File: doc/uart_data_fifo.md
Name: uart_data_fifo

Overview:
Parametrised byte/word FIFO that replaces the fixed 8-entry TX and RX buffers behind the UART register map. It adds the following to the existing push/pop/count behaviour:
- runtime flush
- non-destructive head peek
- configurable fill-level threshold flag (feeds RX interrupt / TX refill request)
- sticky overflow/underflow error flags

One instance sits between the register block and the UART TX serialiser; a second sits between the RX deserialiser and the register block.

Parameters:
DATA_WIDTH, 8, width of each entry in bits (>=1)
DEPTH, 8, number of entries (>=2; any value, power of two not required)
CNT_WIDTH, $clog2(DEPTH+1), width of count/threshold fields (derived, not overridden)

Ports:
clk_i  in  1  clock, all state updates on rising edge
arst_ni  in  1  asynchronous active-low reset
flush_i  in  1  discard all contents (synchronous)
push_i  in  1  write request
data_i  in  DATA_WIDTH  write data
pop_i  in  1  read-and-remove request
data_o  out  DATA_WIDTH  head entry (peek value), valid when empty_o=0
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
count_o  out  CNT_WIDTH  current occupancy 0..DEPTH
thresh_i  in  CNT_WIDTH  fill-level threshold
thresh_o  out  1  count_o >= thresh_i and thresh_i != 0
overflow_o  out  1  sticky: push attempted while full and not accepted
underflow_o  out  1  sticky: pop attempted while empty
clr_err_i  in  1  clear both sticky flags

Behaviour:
- Reset: asynchronous on arst_ni low. wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0. Outputs are empty_o=1, full_o=0, count_o=0, data_o=0, thresh_o=0. Memory array is not reset.
- Storage: DEPTH x DATA_WIDTH register array. Pointers wrap DEPTH-1 -> 0 by explicit compare, not by natural overflow.
- data_o: combinational mem[rd_ptr] when count != 0, else all-zero. It is first-word-fall-through, so a push into an empty FIFO is visible on data_o the cycle after the push edge. There is no same-cycle bypass.
- Priority per cycle: flush > push/pop. flush_i=1 forces wr_ptr=rd_ptr=count=0 and ignores push_i/pop_i in that cycle. Flush does not alter the error flags.
- Push accepted iff push_i and (not full, or pop accepted in the same cycle).
  - Full with simultaneous push+pop: both accepted, count unchanged, pointers both advance.
  - Full with push only: data dropped, overflow set.
- Pop accepted iff pop_i and not empty.
  - Empty with pop: ignored, underflow set.
  - Empty with push+pop: push accepted, pop ignored, underflow set, count -> 1.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. count never leaves 0..DEPTH.
- Sticky flags: clr_err_i clears both flags. If an error event and clr_err_i occur in the same cycle, the set wins (flag ends at 1).
- thresh_o: combinational from registered count and thresh_i. thresh_i=0 disables it (output 0). thresh_i > DEPTH means thresh_o is never asserted.
- full_o/empty_o/count_o: derived from registered count only, never from the current-cycle requests.

Decomposition:
- Shared UART package additions:
  - fifo status struct {count, full, empty, thresh, overflow, underflow}, used by the register block to build the FIFO status registers
  - TX_FIFO_SIZE / RX_FIFO_SIZE constants, supplied as DEPTH
  - default threshold constants
- One natural sub-module: uart_fifo_ptr, a wrap-around pointer counter (enable, clear, MAX = DEPTH-1), instantiated for wr_ptr and rd_ptr.

Test Plan:
1. Reset, then push 0xA5 once -> next cycle data_o=0xA5, count_o=1, empty_o=0. Pop -> count_o=0, data_o=0x00, empty_o=1.
2. Push 0x01..0x08 (DEPTH=8) -> full_o=1, count_o=8. Push 0x09 -> dropped, overflow_o=1. Pop 8 times -> values 0x01..0x08 in order.
3. Full FIFO, push 0x55 and pop in the same cycle -> count stays 8, 0x01 removed, 0x55 becomes the last entry. Repeat 20 cycles to exercise pointer wrap; order is preserved.
4. Empty FIFO, pop -> underflow_o=1. Push 0x3C + pop same cycle -> count_o=1, data_o=0x3C. clr_err_i plus a new pop-on-empty in the same cycle -> underflow_o stays 1.
5. Fill 5 entries, thresh_i=4 -> thresh_o=1. Pop 2 -> thresh_o=0. thresh_i=0 -> thresh_o=0. Flush with push asserted -> count_o=0, the push is ignored, and flags are unchanged.
6. DEPTH=5, DATA_WIDTH=12: push 7 values -> 5 stored, overflow_o=1. arst_ni pulsed mid-sequence (asynchronous, not on an edge) -> immediate count_o=0, empty_o=1, flags cleared.
